buf_pingpong_1r1w: RTL and testbench
====================================

Name: buf_pingpong_1r1w

Overview:
- Parametrised double-buffered (ping-pong) 1-read/1-write RAM buffer for feeding and draining the systolic array.
- The writer fills one bank while the reader consumes the other.
- Bank ownership passes between the two sides through a done/ready handshake.
- Generalises the single-bank 16-bit x 512 buffer: data width and depth are parameters, bank swap is explicit, read data is registered, and reset is synchronous.

Parameters:
- DW, 16, data word width in bits.
- DEPTH, 512, words per bank.
- AW, $clog2(DEPTH), address width (derived; not to be overridden).

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  synchronous active-high reset.
- wr_adr  in  AW  write word address within the current write bank.
- wr_data  in  DW  write data.
- wr_en  in  1  write strobe.
- wr_done  in  1  one-cycle pulse: current write bank is complete; hand it to the reader.
- wr_ready  out  1  a bank is free for writing.
- rd_adr  in  AW  read word address within the current read bank.
- rd_en  in  1  read strobe.
- rd_data  out  DW  registered read data.
- rd_valid  out  1  a full bank is available for reading.
- rd_done  in  1  one-cycle pulse: reader finished its bank; release it.
- rd_perr  out  1  parity error on the last read (only when BUF_PARITY_EN is defined).

Behaviour:
- Storage: two banks of DEPTH x DW, bank 0 and bank 1. Bank state held in registers:
  - wr_bank (1 bit)
  - rd_bank (1 bit)
  - full_cnt (2 bits, range 0..2)
- Reset (rst=1 at posedge): wr_bank=0, rd_bank=0, full_cnt=0, rd_data=0, rd_perr=0. RAM contents are not cleared.
- Outputs are combinational from state:
  - wr_ready = (full_cnt != 2)
  - rd_valid = (full_cnt != 0)
- Write:
  - Occurs when wr_en && wr_ready, storing wr_data at bank[wr_bank][wr_adr].
  - Ignored when !wr_ready.
  - Ignored when wr_adr >= DEPTH (relevant only for non-power-of-2 DEPTH).
- Read:
  - When rd_en && rd_valid, rd_data <= bank[rd_bank][rd_adr]. Latency is 1 cycle.
  - rd_data holds its value otherwise.
  - Out-of-range rd_adr returns 0.
- Read and write always target different banks while both are legal, so there is no read-during-write hazard.
- Handshake events:
  - wr_done accepted only if wr_ready: wr_bank toggles and full_cnt is incremented.
  - rd_done accepted only if rd_valid: rd_bank toggles and full_cnt is decremented.
  - Both accepted in the same cycle: both pointers toggle and full_cnt is unchanged.
  - wr_done while !wr_ready: ignored. rd_done while !rd_valid: ignored.
- State sequence of full_cnt is 0 -> 1 -> 2 and back down.
  - full_cnt=2 means both banks are full; the writer stalls.
  - full_cnt=0 means both banks are empty; the reader stalls.
- A write in the same cycle as an accepted wr_done lands in the old wr_bank.
- A read in the same cycle as an accepted rd_done reads the old rd_bank.
- Reset asserted mid-operation aborts any partially written or read bank. Stale data remains in the RAM but is unreachable until rewritten and handed over.

Optional Feature:
- Macro: BUF_PARITY_EN.
- Defined:
  - Each word stores one extra even-parity bit (XOR of wr_data).
  - On each accepted read, rd_perr <= (stored parity != XOR of the read word), with the same 1-cycle latency as rd_data.
  - rd_perr holds between reads.
- Undefined: no parity storage; rd_perr is tied to 0.

Decomposition:
- Shared package holds the default DW and DEPTH constants and an enum for bank index (BANK0, BANK1).
- One sub-module is natural: buf_bank_1r1w, a single parametrised DW x DEPTH RAM with a registered read port and an optional parity bit. It is instantiated twice.
- The top level holds the bank-control counters/pointers and the output muxing.

Test Plan (DW=16, DEPTH=512):
- Reset, then idle.
  - Expect wr_ready=1, rd_valid=0, rd_data=0.
  - rd_en with rd_adr=5 leaves rd_data=0.
- Write addr 0..511 with data = addr+16'h100, pulse wr_done.
  - Expect rd_valid=1 the next cycle.
  - Reading addr 3 gives 16'h0103 one cycle after rd_en.
- Fill bank 0 + wr_done, then bank 1 + wr_done with no reads.
  - Expect wr_ready=0.
  - A further wr_en with addr 0, data 16'hDEAD is ignored: after two rd_done cycles and a refill with 16'h1111, addr 0 reads 16'h1111.
- full_cnt=1 with simultaneous wr_done and rd_done.
  - Expect full_cnt to stay 1, rd_valid=1, wr_ready=1.
  - Next reads come from the newly completed bank.
- Assert rst mid-fill (after 100 writes).
  - Expect wr_ready=1, rd_valid=0, rd_data=0 in the next cycle.
  - Spurious rd_done while rd_valid=0 is ignored.
- BUF_PARITY_EN defined: force-flip bit 0 of a stored word via hierarchical poke.
  - Reading it gives rd_perr=1.
  - An unflipped word gives rd_perr=0.

Source files
------------

// File: rtl/buf_pingpong_1r1w_pkg.sv
// Shared constants and bank-index type for the ping-pong 1R1W buffer.
package buf_pingpong_1r1w_pkg;

    localparam int unsigned DefaultDw    = 16;
    localparam int unsigned DefaultDepth = 512;

    typedef enum logic {
        BANK0 = 1'b0,
        BANK1 = 1'b1
    } bank_e;

    function automatic bank_e other_bank(input bank_e b);
        return (b == BANK0) ? BANK1 : BANK0;
    endfunction

endpackage

// File: rtl/buf_pingpong_1r1w_bank.sv
// Single DW x DEPTH RAM bank with a registered read port.
// Optional stored even-parity bit when BUF_PARITY_EN is defined.
module buf_bank_1r1w
    import buf_pingpong_1r1w_pkg::*;
#(
    parameter int unsigned DW    = DefaultDw,
    parameter int unsigned DEPTH = DefaultDepth,
    localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o,
    output logic          perr_o
);

`ifdef BUF_PARITY_EN
    localparam int unsigned MW = DW + 1;
`else
    localparam int unsigned MW = DW;
`endif

    logic [MW-1:0] mem [DEPTH];
    logic [MW-1:0] wword;
    logic [MW-1:0] rword;
    logic          wr_ok;
    logic          rd_in_range;
    logic [DW-1:0] rdata_q, rdata_d;

    assign wr_ok       = we_i && (32'(waddr_i) < DEPTH);
    assign rd_in_range = 32'(raddr_i) < DEPTH;

`ifdef BUF_PARITY_EN
    assign wword = {^wdata_i, wdata_i};
`else
    assign wword = wdata_i;
`endif

    always_ff @(posedge clk_i) begin
        if (wr_ok) begin
            mem[waddr_i] <= wword;
        end
    end

    always_comb begin
        rword   = '0;
        rdata_d = rdata_q;
        if (re_i) begin
            if (rd_in_range) begin
                rword = mem[raddr_i];
            end
            rdata_d = rword[DW-1:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata_o = rdata_q;

`ifdef BUF_PARITY_EN
    logic perr_q, perr_d;

    // Out-of-range reads return an all-zero word, which has consistent parity.
    always_comb begin
        perr_d = perr_q;
        if (re_i) begin
            perr_d = rword[DW] != (^rword[DW-1:0]);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perr_q <= 1'b0;
        end else begin
            perr_q <= perr_d;
        end
    end

    assign perr_o = perr_q;
`else
    assign perr_o = 1'b0;
`endif

endmodule

// File: rtl/buf_pingpong_1r1w.sv
// Double-buffered 1R1W buffer: writer fills one bank while reader drains the other.
// Optional read parity checking when BUF_PARITY_EN is defined.
module buf_pingpong_1r1w
    import buf_pingpong_1r1w_pkg::*;
#(
    parameter int unsigned DW    = DefaultDw,
    parameter int unsigned DEPTH = DefaultDepth,
    localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [AW-1:0] wr_adr_i,
    input  logic [DW-1:0] wr_data_i,
    input  logic          wr_en_i,
    input  logic          wr_done_i,
    output logic          wr_ready_o,
    input  logic [AW-1:0] rd_adr_i,
    input  logic          rd_en_i,
    output logic [DW-1:0] rd_data_o,
    output logic          rd_valid_o,
    input  logic          rd_done_i,
    output logic          rd_perr_o
);

    bank_e       wr_bank_q, wr_bank_d;
    bank_e       rd_bank_q, rd_bank_d;
    bank_e       rd_sel_q, rd_sel_d;
    logic [1:0]  full_cnt_q, full_cnt_d;

    logic        wr_fire, rd_fire, wr_acc, rd_acc;
    logic [DW-1:0] rdata0, rdata1;
    logic        perr0, perr1;

    assign wr_ready_o = (full_cnt_q != 2'd2);
    assign rd_valid_o = (full_cnt_q != 2'd0);

    assign wr_fire = wr_en_i && wr_ready_o;
    assign rd_fire = rd_en_i && rd_valid_o;
    assign wr_acc  = wr_done_i && wr_ready_o;
    assign rd_acc  = rd_done_i && rd_valid_o;

    always_comb begin
        wr_bank_d  = wr_bank_q;
        rd_bank_d  = rd_bank_q;
        rd_sel_d   = rd_sel_q;
        full_cnt_d = full_cnt_q;
        if (wr_acc) begin
            wr_bank_d = other_bank(wr_bank_q);
        end
        if (rd_acc) begin
            rd_bank_d = other_bank(rd_bank_q);
        end
        if (wr_acc && !rd_acc) begin
            full_cnt_d = full_cnt_q + 2'd1;
        end else if (!wr_acc && rd_acc) begin
            full_cnt_d = full_cnt_q - 2'd1;
        end
        // Remember which bank produced the last read so rd_data holds between reads.
        if (rd_fire) begin
            rd_sel_d = rd_bank_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_bank_q  <= BANK0;
            rd_bank_q  <= BANK0;
            rd_sel_q   <= BANK0;
            full_cnt_q <= 2'd0;
        end else begin
            wr_bank_q  <= wr_bank_d;
            rd_bank_q  <= rd_bank_d;
            rd_sel_q   <= rd_sel_d;
            full_cnt_q <= full_cnt_d;
        end
    end

    buf_bank_1r1w #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_bank0 (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .we_i    (wr_fire && (wr_bank_q == BANK0)),
        .waddr_i (wr_adr_i),
        .wdata_i (wr_data_i),
        .re_i    (rd_fire && (rd_bank_q == BANK0)),
        .raddr_i (rd_adr_i),
        .rdata_o (rdata0),
        .perr_o  (perr0)
    );

    buf_bank_1r1w #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_bank1 (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .we_i    (wr_fire && (wr_bank_q == BANK1)),
        .waddr_i (wr_adr_i),
        .wdata_i (wr_data_i),
        .re_i    (rd_fire && (rd_bank_q == BANK1)),
        .raddr_i (rd_adr_i),
        .rdata_o (rdata1),
        .perr_o  (perr1)
    );

    always_comb begin
        rd_data_o = (rd_sel_q == BANK1) ? rdata1 : rdata0;
        rd_perr_o = (rd_sel_q == BANK1) ? perr1 : perr0;
    end

endmodule

// File: tb/tb_buf_pingpong_1r1w.sv
// Self-checking bench for buf_pingpong_1r1w (DW=16, DEPTH=512).
module tb_buf_pingpong_1r1w;

    localparam int unsigned DW    = 16;
    localparam int unsigned DEPTH = 512;
    localparam int unsigned AW    = 9;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] wr_adr;
    logic [DW-1:0] wr_data;
    logic          wr_en, wr_done, wr_ready;
    logic [AW-1:0] rd_adr;
    logic          rd_en, rd_done, rd_valid;
    logic [DW-1:0] rd_data;
    logic          rd_perr;

    always #5 clk = ~clk;

    buf_pingpong_1r1w #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .wr_adr_i   (wr_adr),
        .wr_data_i  (wr_data),
        .wr_en_i    (wr_en),
        .wr_done_i  (wr_done),
        .wr_ready_o (wr_ready),
        .rd_adr_i   (rd_adr),
        .rd_en_i    (rd_en),
        .rd_data_o  (rd_data),
        .rd_valid_o (rd_valid),
        .rd_done_i  (rd_done),
        .rd_perr_o  (rd_perr)
    );

    typedef struct {
        logic          wr_en;
        logic [AW-1:0] wr_adr;
        logic [DW-1:0] wr_data;
        logic          wr_done;
        logic          rd_en;
        logic [AW-1:0] rd_adr;
        logic          rd_done;
        logic          exp_wr_ready;
        logic          exp_rd_valid;
        logic [DW-1:0] exp_rd_data;
    } vec_t;

    vec_t vecs [16];

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model of bank ownership and contents.
    logic [DW-1:0] m_mem [2][DEPTH];
    logic          m_bad [2][DEPTH];
    int            m_wr, m_rd, m_full;
    logic [DW-1:0] m_rdata;
    logic          m_perr;
    logic [DW:0]   sb_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                         input logic wdn, input logic re, input logic [AW-1:0] ra,
                         input logic rdn);
        wr_en   = we;
        wr_adr  = wa;
        wr_data = wd;
        wr_done = wdn;
        rd_en   = re;
        rd_adr  = ra;
        rd_done = rdn;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_wr    = 0;
        m_rd    = 0;
        m_full  = 0;
        m_rdata = '0;
        m_perr  = 1'b0;
        sb_q.delete();
        check("reset_wr_ready", 32'(wr_ready), 32'd1);
        check("reset_rd_valid", 32'(rd_valid), 32'd0);
        check("reset_rd_data", 32'(rd_data), 32'd0);
        check("reset_rd_perr", 32'(rd_perr), 32'd0);
    endtask

    // One cycle against the model: expected reads go to the scoreboard and are
    // popped after the edge.
    task automatic step(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        input logic wdn, input logic re, input logic [AW-1:0] ra,
                        input logic rdn);
        bit wrdy, rval;
        drive(we, wa, wd, wdn, re, ra, rdn);
        wrdy = (m_full != 2);
        rval = (m_full != 0);
        if (re && rval) sb_q.push_back({m_bad[m_rd][ra], m_mem[m_rd][ra]});
        if (we && wrdy) begin
            m_mem[m_wr][wa] = wd;
            m_bad[m_wr][wa] = 1'b0;
        end
        if (wdn && wrdy) begin
            m_wr   = 1 - m_wr;
            m_full = m_full + 1;
        end
        if (rdn && rval) begin
            m_rd   = 1 - m_rd;
            m_full = m_full - 1;
        end
        tick();
        if (sb_q.size() > 0) {m_perr, m_rdata} = sb_q.pop_front();
        check("wr_ready", 32'(wr_ready), 32'(m_full != 2));
        check("rd_valid", 32'(rd_valid), 32'(m_full != 0));
        check("rd_data", 32'(rd_data), 32'(m_rdata));
        check("rd_perr", 32'(rd_perr), 32'(m_perr));
    endtask

    initial begin
        //                wen  wadr  wdata    wdn  ren  radr  rdn  wrdy rval rdata
        vecs[0]  = '{1'b0, 9'd0, 16'h0000, 1'b0, 1'b1, 9'd5, 1'b0, 1'b1, 1'b0, 16'h0000};
        vecs[1]  = '{1'b1, 9'd3, 16'hAAAA, 1'b0, 1'b0, 9'd0, 1'b0, 1'b1, 1'b0, 16'h0000};
        vecs[2]  = '{1'b1, 9'd4, 16'h5555, 1'b1, 1'b0, 9'd0, 1'b0, 1'b1, 1'b1, 16'h0000};
        vecs[3]  = '{1'b0, 9'd0, 16'h0000, 1'b0, 1'b1, 9'd3, 1'b0, 1'b1, 1'b1, 16'hAAAA};
        vecs[4]  = '{1'b1, 9'd3, 16'h1234, 1'b0, 1'b1, 9'd4, 1'b0, 1'b1, 1'b1, 16'h5555};
        vecs[5]  = '{1'b0, 9'd0, 16'h0000, 1'b0, 1'b0, 9'd3, 1'b0, 1'b1, 1'b1, 16'h5555};
        vecs[6]  = '{1'b0, 9'd0, 16'h0000, 1'b1, 1'b0, 9'd0, 1'b0, 1'b0, 1'b1, 16'h5555};
        vecs[7]  = '{1'b1, 9'd3, 16'hDEAD, 1'b0, 1'b1, 9'd3, 1'b0, 1'b0, 1'b1, 16'hAAAA};
        vecs[8]  = '{1'b0, 9'd0, 16'h0000, 1'b0, 1'b1, 9'd4, 1'b1, 1'b1, 1'b1, 16'h5555};
        vecs[9]  = '{1'b0, 9'd0, 16'h0000, 1'b0, 1'b1, 9'd3, 1'b0, 1'b1, 1'b1, 16'h1234};
        vecs[10] = '{1'b0, 9'd0, 16'h0000, 1'b1, 1'b0, 9'd0, 1'b1, 1'b1, 1'b1, 16'h1234};
        vecs[11] = '{1'b0, 9'd0, 16'h0000, 1'b0, 1'b1, 9'd3, 1'b0, 1'b1, 1'b1, 16'hAAAA};
        vecs[12] = '{1'b0, 9'd0, 16'h0000, 1'b0, 1'b0, 9'd0, 1'b1, 1'b1, 1'b0, 16'hAAAA};
        vecs[13] = '{1'b0, 9'd0, 16'h0000, 1'b0, 1'b1, 9'd3, 1'b1, 1'b1, 1'b0, 16'hAAAA};
        vecs[14] = '{1'b0, 9'd0, 16'h0000, 1'b1, 1'b0, 9'd0, 1'b0, 1'b1, 1'b1, 16'hAAAA};
        vecs[15] = '{1'b0, 9'd0, 16'h0000, 1'b0, 1'b1, 9'd3, 1'b0, 1'b1, 1'b1, 16'h1234};

        rst = 1'b1;
        drive(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0);
        tick();
        do_reset();

        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].wr_en, vecs[i].wr_adr, vecs[i].wr_data, vecs[i].wr_done,
                  vecs[i].rd_en, vecs[i].rd_adr, vecs[i].rd_done);
            tick();
            check($sformatf("vec%0d_wr_ready", i), 32'(wr_ready), 32'(vecs[i].exp_wr_ready));
            check($sformatf("vec%0d_rd_valid", i), 32'(rd_valid), 32'(vecs[i].exp_rd_valid));
            check($sformatf("vec%0d_rd_data", i), 32'(rd_data), 32'(vecs[i].exp_rd_data));
        end

        // Full-bank fill with wr_done on the last write.
        do_reset();
        for (int i = 0; i < int'(DEPTH); i++) begin
            step(1'b1, AW'(i), 16'(i) + 16'h0100, (i == int'(DEPTH) - 1), 1'b0, '0, 1'b0);
        end
        check("fill_rd_valid", 32'(rd_valid), 32'd1);
        step(1'b0, '0, '0, 1'b0, 1'b1, 9'd3, 1'b0);
        check("fill_read_addr3", 32'(rd_data), 32'h0103);
        step(1'b0, '0, '0, 1'b0, 1'b1, 9'd511, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b1, 9'd0, 1'b0);

        // Second bank, no reads: writer must stall.
        for (int i = 0; i < int'(DEPTH); i++) begin
            step(1'b1, AW'(i), 16'(i) + 16'h0200, (i == int'(DEPTH) - 1), 1'b0, '0, 1'b0);
        end
        check("both_full_wr_ready", 32'(wr_ready), 32'd0);
        step(1'b1, 9'd0, 16'hDEAD, 1'b0, 1'b0, '0, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b1, 9'd0, 1'b1);
        step(1'b0, '0, '0, 1'b0, 1'b1, 9'd0, 1'b1);
        check("drained_rd_valid", 32'(rd_valid), 32'd0);
        for (int i = 0; i < int'(DEPTH); i++) begin
            step(1'b1, AW'(i), 16'h1111, (i == int'(DEPTH) - 1), 1'b0, '0, 1'b0);
        end
        step(1'b0, '0, '0, 1'b0, 1'b1, 9'd0, 1'b0);
        check("refill_read_addr0", 32'(rd_data), 32'h1111);

        // Reset in the middle of filling the other bank.
        for (int i = 0; i < 100; i++) begin
            step(1'b1, AW'(i), 16'hBEEF ^ 16'(i), 1'b0, 1'b0, '0, 1'b0);
        end
        do_reset();
        step(1'b0, '0, '0, 1'b0, 1'b1, 9'd0, 1'b1);
        check("spurious_rd_done", 32'(rd_valid), 32'd0);
        step(1'b0, '0, '0, 1'b1, 1'b0, '0, 1'b0);
        check("after_reset_done_valid", 32'(rd_valid), 32'd1);

`ifdef BUF_PARITY_EN
        do_reset();
        step(1'b1, 9'd7, 16'h00F0, 1'b0, 1'b0, '0, 1'b0);
        step(1'b1, 9'd8, 16'h0101, 1'b1, 1'b0, '0, 1'b0);
        u_dut.u_bank0.mem[7][0] = ~u_dut.u_bank0.mem[7][0];
        m_mem[0][7] = 16'h00F1;
        m_bad[0][7] = 1'b1;
        step(1'b0, '0, '0, 1'b0, 1'b1, 9'd7, 1'b0);
        check("parity_flipped", 32'(rd_perr), 32'd1);
        step(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0);
        check("parity_holds", 32'(rd_perr), 32'd1);
        step(1'b0, '0, '0, 1'b0, 1'b1, 9'd8, 1'b0);
        check("parity_clean", 32'(rd_perr), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
